// File: rtl/uart_pkg.sv
// Shared UART constants: character width, default receive-FIFO depth,
// and the 50 MHz / 9600 baud timing used by the receiver and transmitter.
package uart_pkg;

    localparam int UART_DW         = 8;
    localparam int UART_FIFO_DEPTH = 16;

    localparam int CLK_HZ          = 50_000_000;
    localparam int BAUD            = 9600;
    localparam int CLKS_PER_BIT    = CLK_HZ / BAUD;
    localparam int OVERSAMPLE      = 16;
    localparam int CLKS_PER_SAMPLE = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DATA_BITS       = 8;
    localparam int STOP_BITS       = 1;

    // Per-cycle FIFO activity; encoding is {read, write}.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE  = 2'b00,
        FIFO_OP_WR    = 2'b01,
        FIFO_OP_RD    = 2'b10,
        FIFO_OP_WR_RD = 2'b11
    } fifo_op_t;

    function automatic fifo_op_t fifo_op(input logic wr, input logic rd);
        return fifo_op_t'({rd, wr});
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port RAM: synchronous write, synchronous read-before-write.
// Only the read register is reset; the array itself is never cleared.
module uart_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-address read and write return the old entry, which is what a
    // simultaneous push/pop on a full FIFO needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and its consumer: stores each
// character with its frame-error flag and flags dropped characters.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int DW    = UART_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            rx_data,
    input  logic                     rx_frame_err,
    input  logic                     rx_valid,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     rd_frame_err,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun,
    input  logic                     ovr_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    // Handshake: rx_valid and rd_valid are single-cycle strobes with no
    // back-pressure; rd_en is a request, accepted only when not empty, and
    // answered by rd_valid exactly one cycle later.

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_nxt;
    logic          rd_accept;
    logic          wr_accept;
    logic          drop;
    fifo_op_t      op;
    logic [DW:0]   ram_rdata;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a write alongside an accepted read.
    assign rd_accept = rd_en && !empty && !rst;
    assign wr_accept = rx_valid && (!full || rd_accept) && !rst;
    assign drop      = rx_valid && full && !rd_accept && !rst;
    assign op        = fifo_op(wr_accept, rd_accept);

    always_comb begin
        count_nxt = count;
        case (op)
            FIFO_OP_WR:    count_nxt = count + CNT_ONE;
            FIFO_OP_RD:    count_nxt = count - CNT_ONE;
            default:       count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count    <= count_nxt;
            rd_valid <= rd_accept;
        end
    end

    // A drop in the same cycle as a clear leaves overrun set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    uart_fifo_ram #(
        .DEPTH (DEPTH),
        .W     (DW + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_accept),
        .waddr (wr_ptr),
        .wdata ({rx_frame_err, rx_data}),
        .re    (rd_accept),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // The RAM read register only loads on an accepted read, so these hold
    // their last value between pops.
    assign rd_frame_err = ram_rdata[DW];
    assign rd_data      = ram_rdata[DW-1:0];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario, inline checks,
// expected entries tracked in a queue of {frame_err, data}.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_frame_err;
    logic       rx_valid;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_frame_err;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       ovr_clr;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];

    uart_rx_fifo #(.DEPTH(16), .DW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_frame_err (rx_frame_err),
        .rx_valid     (rx_valid),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_frame_err (rd_frame_err),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr)
    );

    always #10 clk = ~clk;

    // Inputs change just after a falling edge; outputs are sampled at the
    // next falling edge, half a period after the rising edge that used them.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_push(input logic [7:0] d, input logic fe);
        rx_data      = d;
        rx_frame_err = fe;
        rx_valid     = 1'b1;
        tick();
        rx_valid     = 1'b0;
    endtask

    task automatic do_pop(output logic v, output logic [7:0] d, output logic fe);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        v  = rd_valid;
        d  = rd_data;
        fe = rd_frame_err;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        rx_valid     = 1'b1;
        rx_data      = 8'hEE;
        rx_frame_err = 1'b1;
        rd_en        = 1'b1;
        ovr_clr      = 1'b0;
        tick();
        tick();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if ({rd_frame_err, rd_data} !== 9'h000) begin failures++; $display("FAIL reset_rd_data got=%h exp=000", {rd_frame_err, rd_data}); end
        rst      = 1'b0;
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        tick();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_ignored_write got=%0d exp=0", count); end
    endtask

    task automatic test_single();
        logic v, fe;
        logic [7:0] d;
        do_push(8'h75, 1'b0);
        checks++; if (count !== 5'd1 || empty !== 1'b0) begin failures++; $display("FAIL single_count got=%0d/%b exp=1/0", count, empty); end
        tick();
        do_pop(v, d, fe);
        checks++; if ({v, fe, d} !== {1'b1, 1'b0, 8'h75}) begin failures++; $display("FAIL single_pop got=%b/%b/%h exp=1/0/75", v, fe, d); end
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%0d/%b exp=0/1", count, empty); end
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h75) begin failures++; $display("FAIL single_hold got=%b/%h exp=0/75", rd_valid, rd_data); end
    endtask

    task automatic test_overflow();
        logic v, fe;
        logic [7:0] d;
        logic [8:0] e;
        for (int i = 0; i < 16; i++) begin
            do_push(8'(i), 1'b0);
            exp_q.push_back({1'b0, 8'(i)});
        end
        checks++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b0) begin failures++; $display("FAIL ovf_fill got=%b/%0d/%b exp=1/16/0", full, count, overrun); end
        do_push(8'hAA, 1'b0);
        checks++; if (full !== 1'b1 || count !== 5'd16 || overrun !== 1'b1) begin failures++; $display("FAIL ovf_drop got=%b/%0d/%b exp=1/16/1", full, count, overrun); end
        for (int i = 0; i < 16; i++) begin
            do_pop(v, d, fe);
            e = exp_q.pop_front();
            checks++; if ({v, fe, d} !== {1'b1, e}) begin failures++; $display("FAIL ovf_drain[%0d] got=%b/%b/%h exp=1/%h", i, v, fe, d, e); end
        end
        checks++; if (empty !== 1'b1 || count !== 5'd0) begin failures++; $display("FAIL ovf_empty got=%b/%0d exp=1/0", empty, count); end
        do_pop(v, d, fe);
        checks++; if (v !== 1'b0 || d !== 8'h0F || count !== 5'd0) begin failures++; $display("FAIL ovf_pop_empty got=%b/%h/%0d exp=0/0f/0", v, d, count); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overrun); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_full_rw();
        logic v, fe;
        logic [7:0] d;
        logic [8:0] e;
        for (int i = 0; i < 16; i++) begin
            do_push(8'(i), 1'b0);
            exp_q.push_back({1'b0, 8'(i)});
        end
        rx_data      = 8'h55;
        rx_frame_err = 1'b0;
        rx_valid     = 1'b1;
        rd_en        = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        exp_q.push_back(9'h055);
        e = exp_q.pop_front();
        checks++; if ({rd_valid, rd_frame_err, rd_data} !== {1'b1, e}) begin failures++; $display("FAIL full_rw_pop got=%b/%b/%h exp=1/%h", rd_valid, rd_frame_err, rd_data, e); end
        checks++; if (count !== 5'd16 || full !== 1'b1 || overrun !== 1'b0) begin failures++; $display("FAIL full_rw_flags got=%0d/%b/%b exp=16/1/0", count, full, overrun); end
        for (int i = 0; i < 16; i++) begin
            do_pop(v, d, fe);
            e = exp_q.pop_front();
            checks++; if ({v, fe, d} !== {1'b1, e}) begin failures++; $display("FAIL full_rw_drain[%0d] got=%b/%b/%h exp=1/%h", i, v, fe, d, e); end
        end
    endtask

    task automatic test_empty_rw();
        logic v, fe;
        logic [7:0] d;
        rx_data      = 8'h33;
        rx_frame_err = 1'b0;
        rx_valid     = 1'b1;
        rd_en        = 1'b1;
        tick();
        rx_valid = 1'b0;
        rd_en    = 1'b0;
        checks++; if (rd_valid !== 1'b0 || count !== 5'd1) begin failures++; $display("FAIL empty_rw got=%b/%0d exp=0/1", rd_valid, count); end
        do_pop(v, d, fe);
        checks++; if ({v, fe, d} !== {1'b1, 1'b0, 8'h33}) begin failures++; $display("FAIL empty_rw_pop got=%b/%b/%h exp=1/0/33", v, fe, d); end
    endtask

    task automatic test_frame_err();
        logic v, fe;
        logic [7:0] d;
        logic [8:0] e;
        do_push(8'hC3, 1'b1);
        do_pop(v, d, fe);
        checks++; if ({v, fe, d} !== {1'b1, 1'b1, 8'hC3}) begin failures++; $display("FAIL fe_pop got=%b/%b/%h exp=1/1/c3", v, fe, d); end
        for (int i = 0; i < 16; i++) begin
            do_push(8'(8'hA0 + i), i[0]);
            exp_q.push_back({i[0], 8'(8'hA0 + i)});
        end
        rx_data      = 8'h99;
        rx_frame_err = 1'b0;
        rx_valid     = 1'b1;
        ovr_clr      = 1'b1;
        tick();
        rx_valid = 1'b0;
        ovr_clr  = 1'b0;
        checks++; if (overrun !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL fe_set_wins got=%b/%0d exp=1/16", overrun, count); end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL fe_clear got=%b exp=0", overrun); end
        for (int i = 0; i < 16; i++) begin
            do_pop(v, d, fe);
            e = exp_q.pop_front();
            checks++; if ({v, fe, d} !== {1'b1, e}) begin failures++; $display("FAIL fe_drain[%0d] got=%b/%b/%h exp=1/%h", i, v, fe, d, e); end
        end
    endtask

    task automatic test_wrap_reset();
        logic v, fe;
        logic [7:0] d;
        logic [7:0] x;
        for (int i = 0; i < 40; i++) begin
            x = 8'(i * 7 + 3);
            do_push(x, 1'b0);
            do_pop(v, d, fe);
            checks++; if ({v, d} !== {1'b1, x}) begin failures++; $display("FAIL wrap[%0d] got=%b/%h exp=1/%h", i, v, d, x); end
        end
        for (int i = 0; i < 5; i++) begin
            do_push(8'(8'h40 + i), 1'b0);
        end
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL wrap_count got=%0d exp=5", count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL midreset got=%0d/%b/%b exp=0/1/0", count, empty, rd_valid); end
        do_pop(v, d, fe);
        checks++; if (v !== 1'b0) begin failures++; $display("FAIL midreset_pop got=%b exp=0", v); end
        do_push(8'h12, 1'b0);
        do_pop(v, d, fe);
        checks++; if ({v, fe, d} !== {1'b1, 1'b0, 8'h12}) begin failures++; $display("FAIL after_reset got=%b/%b/%h exp=1/0/12", v, fe, d); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_frame_err();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
